ilf_deser_sp: RTL and testbench



---
 rtl/ilf_deser_sp.sv | 103 ++++++++++
 tb/tb_ilf_deser_sp.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ilf_deser_sp.sv
// Per-lane input capture followed by a serial-to-parallel gearbox.
// Lanes share the bit counter, sample enable and bit-slip control.
module ilf_deser_sp #(
  parameter int    WIDTH     = 1,
  parameter int    RATIO     = 4,
  parameter bit    LSB_FIRST = 1'b1,
  parameter string REGSET    = "RESET",
  parameter string GSR       = "ENABLED"
) (
  input  logic                       CK,
  input  logic                       CD,
  input  logic [WIDTH-1:0]           D,
  input  logic                       SP,
  input  logic                       SLIP,
  output logic [WIDTH*RATIO-1:0]     Q,
  output logic                       QVALID,
  output logic [$clog2(RATIO)-1:0]   PHASE
);

  localparam int            CW      = $clog2(RATIO);
  localparam logic [CW-1:0] LAST    = CW'(RATIO - 1);
  localparam bit            FILL    = (REGSET == "SET");
  localparam bit            HAS_GSR = (GSR == "ENABLED");

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("ilf_deser_sp: WIDTH must be in 1..16");
  end
  if (RATIO < 2 || RATIO > 8) begin : g_bad_ratio
    $error("ilf_deser_sp: RATIO must be in 2..8");
  end
  if (REGSET != "SET" && REGSET != "RESET") begin : g_bad_regset
    $error("ilf_deser_sp: REGSET must be \"SET\" or \"RESET\"");
  end
  if (GSR != "ENABLED" && GSR != "DISABLED") begin : g_bad_gsr
    $error("ilf_deser_sp: GSR must be \"ENABLED\" or \"DISABLED\"");
  end

  logic [CW-1:0]          cnt;
  logic                   qvalid;
  logic [WIDTH-1:0]       d1;
  logic [WIDTH*RATIO-1:0] sr;
  logic [WIDTH*RATIO-1:0] sr_next;
  logic [WIDTH*RATIO-1:0] q;
  logic                   complete;

  // A slipped bit is still shifted in; only the counter holds, so the
  // word boundary moves one accepted bit later.
  assign complete = SP && !SLIP && (cnt == LAST);

  // NOTE: assigning a default before the loop keeps this purely
  // combinational; a missing default on any path would infer a latch.
  always_comb begin
    sr_next = sr;
    for (int l = 0; l < WIDTH; l++) begin
      if (LSB_FIRST)
        sr_next[l*RATIO +: RATIO] = {d1[l], sr[l*RATIO+1 +: RATIO-1]};
      else
        sr_next[l*RATIO +: RATIO] = {sr[l*RATIO +: RATIO-1], d1[l]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      cnt    <= '0;
      qvalid <= 1'b0;
    end else begin
      qvalid <= complete;
      if (SP && !SLIP)
        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // NOTE: whether the data path is reset is a parameter choice; without
  // it the data registers simply freeze while CD is high.
  if (HAS_GSR) begin : g_data_rst
    always_ff @(posedge CK or posedge CD) begin
      if (CD) begin
        d1 <= {WIDTH{FILL}};
        sr <= {(WIDTH*RATIO){FILL}};
        q  <= {(WIDTH*RATIO){FILL}};
      end else begin
        d1 <= D;
        if (SP)       sr <= sr_next;
        if (complete) q  <= sr_next;
      end
    end
  end else begin : g_data_hold
    always_ff @(posedge CK) begin
      if (!CD) begin
        d1 <= D;
        if (SP)       sr <= sr_next;
        if (complete) q  <= sr_next;
      end
    end
  end

  assign Q      = q;
  assign QVALID = qvalid;
  assign PHASE  = cnt;

endmodule

// File: tb/tb_ilf_deser_sp.sv
// Three gearbox configurations driven in lockstep, compared every cycle
// against a bit-history model plus hand-computed anchor values.
`timescale 1ns/1ps
module tb_ilf_deser_sp;

  logic       ck = 1'b0;
  logic       cd;
  logic [1:0] d;
  logic       sp;
  logic       slip;

  logic [7:0]  q0, q1;
  logic [15:0] q2;
  logic        qv0, qv1, qv2;
  logic [1:0]  ph0, ph1;
  logic [2:0]  ph2;

  always #5 ck = ~ck;

  // u0: RATIO 4, LSB first, reset to 0, full reset
  ilf_deser_sp #(.WIDTH(2), .RATIO(4), .LSB_FIRST(1'b1), .REGSET("RESET"), .GSR("ENABLED"))
    u0 (.CK(ck), .CD(cd), .D(d), .SP(sp), .SLIP(slip), .Q(q0), .QVALID(qv0), .PHASE(ph0));
  // u1: RATIO 4, MSB first, reset to 1, full reset
  ilf_deser_sp #(.WIDTH(2), .RATIO(4), .LSB_FIRST(1'b0), .REGSET("SET"), .GSR("ENABLED"))
    u1 (.CK(ck), .CD(cd), .D(d), .SP(sp), .SLIP(slip), .Q(q1), .QVALID(qv1), .PHASE(ph1));
  // u2: RATIO 8, LSB first, data registers not reset
  ilf_deser_sp #(.WIDTH(2), .RATIO(8), .LSB_FIRST(1'b1), .REGSET("RESET"), .GSR("DISABLED"))
    u2 (.CK(ck), .CD(cd), .D(d), .SP(sp), .SLIP(slip), .Q(q2), .QVALID(qv2), .PHASE(ph2));

  int n_vec  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Model state: per instance, per lane history of accepted bits (index 0 newest)
  int          cnt_m  [3];
  bit          qv_m   [3];
  logic [15:0] q_m    [3];
  bit          hist   [3][2][8];
  logic [1:0]  dprev  [3];
  bit          qknown [3];

  function automatic int rat(input int k);   return (k == 2) ? 8 : 4; endfunction
  function automatic bit lsbf(input int k);  return (k != 1);         endfunction
  function automatic bit fillv(input int k); return (k == 1);         endfunction
  function automatic bit gsren(input int k); return (k != 2);         endfunction

  function automatic logic [31:0] dut_q(input int k);
    case (k)
      0:       return {24'b0, q0};
      1:       return {24'b0, q1};
      default: return {16'b0, q2};
    endcase
  endfunction
  function automatic logic [31:0] dut_qv(input int k);
    case (k)
      0:       return {31'b0, qv0};
      1:       return {31'b0, qv1};
      default: return {31'b0, qv2};
    endcase
  endfunction
  function automatic logic [31:0] dut_ph(input int k);
    case (k)
      0:       return {30'b0, ph0};
      1:       return {30'b0, ph1};
      default: return {29'b0, ph2};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    cnt_m[k] = 0;
    qv_m[k]  = 1'b0;
    if (gsren(k)) begin
      for (int l = 0; l < 2; l++)
        for (int j = 0; j < 8; j++) hist[k][l][j] = fillv(k);
      dprev[k]  = {2{fillv(k)}};
      q_m[k]    = fillv(k) ? 16'hFFFF >> (16 - 2*rat(k)) : 16'h0;
      qknown[k] = 1'b1;
    end
  endtask

  // One rising edge: accept the previously captured bit when s=1, then capture dn.
  task automatic model_edge(input int k, input bit s, input bit sl, input logic [1:0] dn);
    int r;
    r = rat(k);
    qv_m[k] = 1'b0;
    if (s) begin
      for (int l = 0; l < 2; l++) begin
        for (int j = 7; j > 0; j--) hist[k][l][j] = hist[k][l][j-1];
        hist[k][l][0] = dprev[k][l];
      end
      if (!sl) begin
        if (cnt_m[k] == r - 1) begin
          cnt_m[k]  = 0;
          qv_m[k]   = 1'b1;
          qknown[k] = 1'b1;
          q_m[k]    = '0;
          // The word is the last r accepted bits; hist[r-1] is the oldest.
          for (int l = 0; l < 2; l++)
            for (int i = 0; i < r; i++)
              q_m[k][l*r+i] = lsbf(k) ? hist[k][l][r-1-i] : hist[k][l][i];
        end else begin
          cnt_m[k]++;
        end
      end
    end
    dprev[k] = dn;
  endtask

  // Apply inputs, advance the model, and return 1 ns after the rising edge.
  task automatic tick(input bit s, input bit sl, input logic [1:0] dv);
    sp   = s;
    slip = sl;
    d    = dv;
    for (int k = 0; k < 3; k++) model_edge(k, s, sl, dv);
    @(posedge ck);
    #1;
  endtask

  // Called 1 ns after an edge; CD is high from +2 to +5 ns.
  task automatic cd_assert();
    #1;
    cd = 1'b1;
    for (int k = 0; k < 3; k++) model_reset(k);
    #1;
  endtask
  task automatic cd_release();
    #2;
    cd = 1'b0;
  endtask

  always @(posedge ck) begin
    #1;
    if (cmp_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("u%0d_phase", k), dut_ph(k), cnt_m[k]);
        check($sformatf("u%0d_qvalid", k), dut_qv(k), {31'b0, qv_m[k]});
        if (qknown[k]) check($sformatf("u%0d_q", k), dut_q(k), {16'b0, q_m[k]});
      end
    end
  end

  initial begin
    cd = 1'b1; sp = 1'b0; slip = 1'b0; d = 2'b00;
    for (int k = 0; k < 3; k++) begin
      qknown[k] = 1'b0;
      q_m[k]    = '0;
      dprev[k]  = '0;
      for (int l = 0; l < 2; l++)
        for (int j = 0; j < 8; j++) hist[k][l][j] = 1'b0;
      model_reset(k);
    end
    #12;
    check("rst_q0", {24'b0, q0}, 32'h00);
    check("rst_q1", {24'b0, q1}, 32'hFF);
    check("rst_qv", {29'b0, qv0, qv1, qv2}, 32'h0);
    check("rst_ph0", {30'b0, ph0}, 32'h0);
    check("rst_ph2", {29'b0, ph2}, 32'h0);
    #1;
    cd = 1'b0;
    cmp_en = 1'b1;

    // Lane0 D = 1,0,1,1 on edges 1..4; accepting from edge 2.
    tick(1'b0, 1'b0, 2'b01);
    tick(1'b1, 1'b0, 2'b00);
    check("seqA_ph_e2", {30'b0, ph0}, 32'd1);
    tick(1'b1, 1'b0, 2'b01);
    check("seqA_ph_e3", {30'b0, ph0}, 32'd2);
    tick(1'b1, 1'b0, 2'b01);
    check("seqA_ph_e4", {30'b0, ph0}, 32'd3);
    tick(1'b1, 1'b0, 2'b00);
    check("seqA_ph_e5", {30'b0, ph0}, 32'd0);
    check("seqA_qv_e5", {31'b0, qv0}, 32'd1);
    check("seqA_q0_lsb", {24'b0, q0}, 32'h0D);
    check("seqA_q1_msb", {24'b0, q1}, 32'h0B);
    tick(1'b0, 1'b0, 2'b01);
    check("seqA_qv_e6", {31'b0, qv0}, 32'd0);

    // Constant lane0=1, lane1=0.
    repeat (16) tick(1'b1, 1'b0, 2'b01);
    check("const_q2", {16'b0, q2}, 32'h00FF);
    check("const_q0", {24'b0, q0}, 32'h0F);
    check("const_q1", {24'b0, q1}, 32'h0F);

    // Reset mid-word at PHASE 2.
    for (int i = 0; i < 8 && ph0 != 2'd2; i++) tick(1'b1, 1'b0, 2'b01);
    check("seek_phase2", {30'b0, ph0}, 32'd2);
    cd_assert();
    check("cd_q0_reset", {24'b0, q0}, 32'h00);
    check("cd_q1_set", {24'b0, q1}, 32'hFF);
    check("cd_q2_hold", {16'b0, q2}, 32'h00FF);
    check("cd_qv", {29'b0, qv0, qv1, qv2}, 32'h0);
    check("cd_ph0", {30'b0, ph0}, 32'h0);
    check("cd_ph2", {29'b0, ph2}, 32'h0);
    cd_release();

    // SP gap on edge 3: completion moves to edge 6.
    tick(1'b0, 1'b0, 2'b01);
    tick(1'b1, 1'b0, 2'b00);
    tick(1'b0, 1'b0, 2'b00);
    tick(1'b1, 1'b0, 2'b01);
    tick(1'b1, 1'b0, 2'b01);
    check("gap_qv_e5", {31'b0, qv0}, 32'd0);
    tick(1'b1, 1'b0, 2'b00);
    check("gap_q0_e6", {24'b0, q0}, 32'h0D);
    check("gap_qv_e6", {31'b0, qv0}, 32'd1);

    // Repeating 0001 on lane0 with one slip at PHASE 1.
    cd_assert();
    cd_release();
    for (int n = 1; n <= 24; n++)
      tick(n != 1, n == 7, {1'b0, ((n - 1) % 4 == 0)});

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        cd_assert();
        cd_release();
      end
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, 2'($urandom_range(0, 3)));
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
